// File: rtl/ghost_pkg.sv
// Shared constants for the ghost sprite arbiter: geometry defaults and the
// colour encodings used when recolouring the shared ghost bitmap.
package ghost_pkg;
    localparam int NUM_GHOSTS  = 4;
    localparam int SPRITE_SIZE = 32;
    localparam int COORD_W     = 11;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam logic [7:0] BODY_COLOR           = 8'hE0;
    localparam logic [7:0] FRIGHT_BLUE          = 8'h03;
    localparam logic [7:0] FLASH_GREY           = 8'hB6;

    // Entry 0 is ghost 0; ghosts beyond 4 reuse the palette cyclically.
    localparam logic [3:0][7:0] GHOST_PALETTE = {8'hF0, 8'h1F, 8'hF3, 8'hE0};

    function automatic logic [7:0] ghost_colour(input logic [31:0] id);
        return GHOST_PALETTE[id[1:0]];
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first request at or after ptr_i,
// searching cyclically, plus any/multiple-request flags.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o,
    output logic          multi_o
);
    int g;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        g       = 0;
        for (int k = 0; k < N; k++) begin
            g = (int'(ptr_i) + k) % N;
            if (req_i[g] && grant_o == '0) begin
                grant_o[g] = 1'b1;
                idx_o      = IW'(g);
            end
        end
    end

    assign any_o   = |req_i;
    assign multi_o = $countones(req_i) >= 2;
endmodule

// File: rtl/ghost_draw_arbiter.sv
// Arbitrates NUM_GHOSTS rectangles onto one shared ghost bitmap and recolours
// the returned pixel; pixel in -> drawingRequest/RGBout out in exactly 2 clocks.
module ghost_draw_arbiter #(
    parameter int NUM_GHOSTS  = ghost_pkg::NUM_GHOSTS,
    parameter int SPRITE_SIZE = ghost_pkg::SPRITE_SIZE,
    parameter int COORD_W     = ghost_pkg::COORD_W,
    parameter int IDW         = $clog2(NUM_GHOSTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic [COORD_W-1:0]            pixelX,
    input  logic [COORD_W-1:0]            pixelY,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghostTopLeftX,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghostTopLeftY,
    input  logic [NUM_GHOSTS-1:0]         ghostEnable,
    input  logic [NUM_GHOSTS-1:0]         ghostFrightened,
    input  logic                          frightFlash,
    output logic [COORD_W-1:0]            bmOffsetX,
    output logic [COORD_W-1:0]            bmOffsetY,
    output logic                          bmInsideRectangle,
    input  logic [7:0]                    bmRGB,
    input  logic                          bmDrawingRequest,
    output logic                          drawingRequest,
    output logic [7:0]                    RGBout,
    output logic [IDW-1:0]                ghostId,
    output logic                          ghostOverlap
);
    import ghost_pkg::*;

    localparam logic [COORD_W:0] SPR = (COORD_W+1)'(SPRITE_SIZE);

    logic [NUM_GHOSTS-1:0][COORD_W-1:0] tlx, tly;
    logic [NUM_GHOSTS-1:0] hit, grant;
    logic [IDW-1:0]        win_idx;
    logic                  any_hit, multi_hit;

    logic [IDW-1:0]     rr_q, rr_d;
    logic [4:0]         fc_q, fc_d;
    logic [COORD_W-1:0] offx_q, offx_d, offy_q, offy_d;
    logic               in1_q, in1_d, fr1_q, fr1_d, ov1_q, ov1_d;
    logic [IDW-1:0]     id1_q, id1_d, id2_q;
    logic               v2_q, fr2_q, ov2_q;

    assign tlx = ghostTopLeftX;
    assign tly = ghostTopLeftY;

    // Compare one bit wider so a sprite near the right/bottom edge never wraps.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            hit[i] = ghostEnable[i]
                && ({1'b0, pixelX} >= {1'b0, tlx[i]}) && ({1'b0, pixelX} < {1'b0, tlx[i]} + SPR)
                && ({1'b0, pixelY} >= {1'b0, tly[i]}) && ({1'b0, pixelY} < {1'b0, tly[i]} + SPR);
        end
    end

    rr_priority_picker #(.N(NUM_GHOSTS), .IW(IDW)) u_pick (
        .req_i   (hit),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_hit),
        .multi_o (multi_hit)
    );

    always_comb begin
        in1_d  = any_hit;
        offx_d = any_hit ? pixelX - tlx[win_idx] : '0;
        offy_d = any_hit ? pixelY - tly[win_idx] : '0;
        id1_d  = any_hit ? win_idx : '0;
        fr1_d  = any_hit && ghostFrightened[win_idx];
        ov1_d  = multi_hit;
        rr_d   = rr_q;
        fc_d   = fc_q;
        if (startOfFrame) begin
            rr_d = (rr_q == IDW'(NUM_GHOSTS-1)) ? '0 : rr_q + 1'b1;
            fc_d = fc_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q   <= '0;
            fc_q   <= '0;
            in1_q  <= 1'b0;
            offx_q <= '0;
            offy_q <= '0;
            id1_q  <= '0;
            fr1_q  <= 1'b0;
            ov1_q  <= 1'b0;
            v2_q   <= 1'b0;
            id2_q  <= '0;
            fr2_q  <= 1'b0;
            ov2_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            fc_q   <= fc_d;
            in1_q  <= in1_d;
            offx_q <= offx_d;
            offy_q <= offy_d;
            id1_q  <= id1_d;
            fr1_q  <= fr1_d;
            ov1_q  <= ov1_d;
            v2_q   <= in1_q;
            id2_q  <= id1_q;
            fr2_q  <= fr1_q;
            ov2_q  <= ov1_q;
        end
    end

    assign bmInsideRectangle = in1_q;
    assign bmOffsetX         = offx_q;
    assign bmOffsetY         = offy_q;

    // Bitmap data arrives one clock after the offsets, so recolour combinationally
    // against the stage-2 copy of the winner's attributes.
    always_comb begin
        RGBout = TRANSPARENT_ENCODING;
        if (v2_q) begin
            if (bmRGB == BODY_COLOR) begin
                if (fr2_q)
                    RGBout = (frightFlash && fc_q[4]) ? FLASH_GREY : FRIGHT_BLUE;
                else
                    RGBout = ghost_colour(32'(id2_q));
            end else begin
                RGBout = bmRGB;
            end
        end
    end

    assign drawingRequest = v2_q && bmDrawingRequest;
    assign ghostId        = id2_q;
    assign ghostOverlap   = ov2_q;
endmodule

// File: tb/tb_ghost_draw_arbiter.sv
// Bench for ghost_draw_arbiter: behavioural ghost/bitmap model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ghost_draw_arbiter;
    localparam int NG = 4;
    localparam int CW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, startOfFrame = 1'b0, frightFlash = 1'b0;
    logic [CW-1:0] pixelX = '0, pixelY = '0;
    logic [NG*CW-1:0] gx, gy;
    logic [NG-1:0] en = '0, fr = '0;
    logic [CW-1:0] bmOffsetX, bmOffsetY;
    logic bmInsideRectangle;
    logic [7:0] bmRGB = 8'hFF;
    logic bmDrawingRequest = 1'b0;
    logic drawingRequest, ghostOverlap;
    logic [7:0] RGBout;
    logic [1:0] ghostId;

    int tx[NG], ty[NG];
    int total = 0, bad = 0;
    logic [7:0] pal [NG] = '{8'hE0, 8'hF3, 8'h1F, 8'hF0};

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < NG; i++) begin
            gx[i*CW +: CW] = CW'(tx[i]);
            gy[i*CW +: CW] = CW'(ty[i]);
        end
    end

    ghost_draw_arbiter dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .ghostTopLeftX(gx), .ghostTopLeftY(gy),
        .ghostEnable(en), .ghostFrightened(fr), .frightFlash(frightFlash),
        .bmOffsetX(bmOffsetX), .bmOffsetY(bmOffsetY), .bmInsideRectangle(bmInsideRectangle),
        .bmRGB(bmRGB), .bmDrawingRequest(bmDrawingRequest),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .ghostId(ghostId), .ghostOverlap(ghostOverlap)
    );

    // Sprite artwork: eyes in cols 8..15 of rows 0..7, a non-body stripe in rows 24+.
    function automatic void bitmap(input int ox, input int oy, input bit ins,
                                   output logic [7:0] rgb, output bit drq);
        if (!ins) rgb = 8'hFF;
        else if (ox >= 8 && ox < 16 && oy < 8) rgb = 8'hFF;
        else if (oy >= 24) rgb = 8'h1C;
        else rgb = 8'hE0;
        drq = (rgb != 8'hFF);
    endfunction

    always @(posedge clk) begin : shared_bitmap
        logic [7:0] r;
        bit d;
        bitmap(int'(bmOffsetX), int'(bmOffsetY), bmInsideRectangle === 1'b1, r, d);
        bmRGB <= r;
        bmDrawingRequest <= d;
    end

    typedef struct packed { bit v; int ox; int oy; int id; bit fr; bit ov; } stg_t;
    stg_t e1 = '0, e2 = '0;
    int rr = 0, fc = 0;

    function automatic stg_t predict(input int px, input int py, input int r);
        stg_t s;
        int n;
        s = '0;
        n = 0;
        for (int k = 0; k < NG; k++) begin
            int g;
            g = (r + k) % NG;
            if (en[g] && px >= tx[g] && px < tx[g] + 32 && py >= ty[g] && py < ty[g] + 32) begin
                n++;
                if (!s.v) begin
                    s.v = 1; s.id = g; s.ox = px - tx[g]; s.oy = py - ty[g]; s.fr = fr[g];
                end
            end
        end
        s.ov = (n >= 2);
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e1 = '0; e2 = '0; rr = 0; fc = 0;
        end else begin
            e2 = e1;
            e1 = predict(int'(pixelX), int'(pixelY), rr);
            if (startOfFrame) begin
                rr = (rr + 1) % NG;
                fc = (fc + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [7:0] rb, ergb;
        bit bd, edr;
        int eid;
        bit eov;
        total++;
        if (bmInsideRectangle !== e1.v || bmOffsetX !== CW'(e1.ox) || bmOffsetY !== CW'(e1.oy)) begin
            bad++;
            $display("FAIL stage1 t=%0t got in=%b ox=%0d oy=%0d want in=%b ox=%0d oy=%0d",
                     $time, bmInsideRectangle, bmOffsetX, bmOffsetY, e1.v, e1.ox, e1.oy);
        end
        edr = 0; ergb = 8'hFF; eid = 0; eov = 0;
        if (e2.v) begin
            bitmap(e2.ox, e2.oy, 1'b1, rb, bd);
            edr = bd;
            if (rb == 8'hE0)
                ergb = e2.fr ? ((frightFlash && fc[4]) ? 8'hB6 : 8'h03) : pal[e2.id];
            else
                ergb = rb;
            eid = e2.id;
            eov = e2.ov;
        end
        total++;
        if (drawingRequest !== edr || RGBout !== ergb || ghostId !== 2'(eid) || ghostOverlap !== eov) begin
            bad++;
            $display("FAIL stage2 t=%0t got dr=%b rgb=%h id=%0d ov=%b want dr=%b rgb=%h id=%0d ov=%b",
                     $time, drawingRequest, RGBout, ghostId, ghostOverlap, edr, ergb, eid, eov);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Hold inputs steady until their stage-2 result is visible.
    task automatic settle();
        @(posedge clk); @(posedge clk); @(negedge clk);
    endtask

    task automatic pix(input int x, input int y);
        pixelX = CW'(x); pixelY = CW'(y);
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NG; i++) begin tx[i] = 0; ty[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", RGBout, 8'hFF);
        chk("reset_dr", drawingRequest, 0);
        chk("reset_inside", bmInsideRectangle, 0);
        chk("reset_id", ghostId, 0);
        step(); reset = 1'b0;

        // Single ghost sweep across its full width and one pixel past it.
        tx[0] = 100; ty[0] = 100; en = 4'b0001;
        for (int x = 100; x <= 132; x++) begin pix(x, 100); step(); end
        pix(120, 103); settle();
        chk("g0_offx", bmOffsetX, 20);
        chk("g0_offy", bmOffsetY, 3);
        chk("g0_dr", drawingRequest, 1);
        chk("g0_rgb", RGBout, 8'hE0);
        step(); pix(132, 103); settle();
        chk("g0_edge_inside", bmInsideRectangle, 0);
        chk("g0_edge_dr", drawingRequest, 0);

        // Two ghosts stacked: rotation decides the winner.
        step(); en = 4'b0110; tx[1] = 200; ty[1] = 50; tx[2] = 200; ty[2] = 50;
        pix(210, 60); settle();
        chk("ovl_id_rr0", ghostId, 1);
        chk("ovl_flag", ghostOverlap, 1);
        chk("ovl_rgb_rr0", RGBout, 8'hF3);
        step(); pulse(2); settle();
        chk("ovl_id_rr2", ghostId, 2);
        chk("ovl_rgb_rr2", RGBout, 8'h1F);

        // Ghost 3 palette, eye transparency, non-body passthrough.
        step(); en = 4'b1000; tx[3] = 300; ty[3] = 300;
        pix(320, 305); settle();
        chk("g3_body", RGBout, 8'hF0);
        step(); pix(310, 305); settle();
        chk("g3_eye_dr", drawingRequest, 0);
        step(); pix(320, 330); settle();
        chk("g3_pass", RGBout, 8'h1C);

        // Frightened colouring and flash toggle on frameCnt bit 4 (frameCnt=2 here).
        step(); en = 4'b0100; fr = 4'b0100; pix(210, 60); settle();
        chk("fright_blue", RGBout, 8'h03);
        step(); frightFlash = 1'b1; settle();
        chk("flash_low_fc", RGBout, 8'h03);
        step(); pulse(14); settle();
        chk("flash_grey", RGBout, 8'hB6);
        step(); fr = 4'b0000; settle();
        chk("flash_ignored", RGBout, 8'h1F);
        step(); fr = 4'b0100; pulse(16); settle();
        chk("flash_back_blue", RGBout, 8'h03);
        step(); frightFlash = 1'b0; fr = 4'b0000;

        // Sprite at the right screen edge must not wrap to x=0.
        en = 4'b0001; tx[0] = 2040; ty[0] = 100; pix(5, 110); settle();
        chk("wrap_inside", bmInsideRectangle, 0);
        step(); pix(2045, 110); settle();
        chk("edge_inside", bmInsideRectangle, 1);
        chk("edge_offx", bmOffsetX, 5);

        // Disable the winner mid-line (rotation pointer is back at 0 here).
        step(); en = 4'b0110;
        for (int x = 200; x < 222; x++) begin
            if (x == 208) en = 4'b0100;
            if (x == 214) en = 4'b0110;
            pix(x, 60); step();
        end
        pix(215, 60); settle();
        chk("tog_before", ghostId, 1);
        step(); en = 4'b0100; settle();
        chk("tog_after", ghostId, 2);
        chk("tog_inside", bmInsideRectangle, 1);

        // Reset in the middle of an active span.
        step(); en = 4'b0001; tx[0] = 100; ty[0] = 100;
        for (int x = 100; x < 110; x++) begin pix(x, 103); step(); end
        pix(120, 103); reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_dr", drawingRequest, 0);
        chk("mid_rst_rgb", RGBout, 8'hFF);
        chk("mid_rst_inside", bmInsideRectangle, 0);
        chk("mid_rst_offx", bmOffsetX, 0);
        step(); reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rel_dr_c1", drawingRequest, 0);
        chk("rel_inside_c1", bmInsideRectangle, 1);
        @(posedge clk); @(negedge clk);
        chk("rel_dr_c2", drawingRequest, 1);
        chk("rel_rgb_c2", RGBout, 8'hE0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
